// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: done pulses WIDTH+2 cycles after start is taken; start/Awrite/Bwrite are ignored while busy.
// Define BOOTH_EARLY_DONE_EN to bypass the CALC phase when either operand is zero (done one cycle after start is taken).
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic               Awrite,
    input  logic [WIDTH-1:0]   B,
    input  logic               Bwrite,
    input  logic               mode,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     qr_q, qr_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH+1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH+1:0]   m_ext;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+3:0] shv;

    // Mode is captured in the extension of M and Q at LOAD, so no separate mode register is kept.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        qr_d     = qr_q;
        qm1_d    = qm1_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        m_ext = {m_q[WIDTH], m_q};
        case ({qr_q[0], qm1_q})
            2'b01:   sum = acc_q + m_ext;
            2'b10:   sum = acc_q - m_ext;
            default: sum = acc_q;
        endcase
        shv = {sum[WIDTH+1], sum, qr_q};

        if ((state_q == S_IDLE || state_q == S_DONE) && Awrite) a_d = A;
        if ((state_q == S_IDLE || state_q == S_DONE) && Bwrite) b_d = B;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                m_d     = mode ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
                qr_d    = mode ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};
                acc_d   = '0;
                qm1_d   = 1'b0;
                cnt_d   = CW'(WIDTH + 1);
                state_d = S_CALC;
`ifdef BOOTH_EARLY_DONE_EN
                if (a_q == '0 || b_q == '0) begin
                    state_d  = S_DONE;
                    result_d = '0;
                end
`endif
            end
            S_CALC: begin
                acc_d = shv[2*WIDTH+3:WIDTH+2];
                qr_d  = shv[WIDTH+1:1];
                qm1_d = shv[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = {shv[2*WIDTH:WIDTH+2], shv[WIDTH+1:1]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            qr_q     <= '0;
            qm1_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            qr_q     <= qr_d;
            qm1_q    <= qm1_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_LOAD) || (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign Result = result_q;

endmodule
